// File: rtl/dpll_lock_detector.sv
// DPLL lock monitor: measures the reference period and the feedback phase
// error in the oscInput domain, and runs a hysteretic lock FSM.
`timescale 1ns/1ps
module dpll_lock_detector #(
  parameter int CNT_WIDTH    = 20,
  parameter int PHASE_TOL    = 16,
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int REF_TIMEOUT  = 1048575
) (
  input  logic                        oscInput,
  input  logic                        reset,
  input  logic                        refIn,
  input  logic                        fbIn,
  output logic                        locked,
  output logic [1:0]                  lockState,
  output logic signed [CNT_WIDTH:0]   phaseErr,
  output logic                        errValid,
  output logic [CNT_WIDTH-1:0]        refPeriod,
  output logic                        lossOfRef
);

  localparam int GW = $clog2(LOCK_COUNT + 1) + 1;
  localparam int BW = $clog2(UNLOCK_COUNT + 1) + 1;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    ACQUIRING = 2'd1,
    LOCKED    = 2'd2,
    HOLDOVER  = 2'd3
  } state_e;

  logic [2:0]                 ref_sync_q, fb_sync_q;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d, cnt_inc, half;
  logic [CNT_WIDTH-1:0]       t_q, t_d;
  logic                       fb_seen_q, fb_seen_d;
  logic                       first_q, first_d;
  logic                       los_q, los_d;
  logic [CNT_WIDTH-1:0]       period_q, period_d;
  logic signed [CNT_WIDTH:0]  err_q, err_d, err, err_abs;
  logic                       ev_q, ev_d;
  state_e                     state_q, state_d;
  logic [GW-1:0]              good_q, good_d, good_inc;
  logic [BW-1:0]              bad_q, bad_d, bad_inc;
  logic                       ref_edge, fb_edge, good;

  assign ref_edge = ref_sync_q[1] & ~ref_sync_q[2];
  assign fb_edge  = fb_sync_q[1] & ~fb_sync_q[2];

  always_comb begin
    // cnt_inc is "cycles since the last ref edge", including this one
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    half     = cnt_inc >> 1;
    err      = (t_q <= half) ? {1'b0, t_q}
                             : {1'b0, t_q} - {1'b0, cnt_inc};
    err_abs  = err[CNT_WIDTH] ? -err : err;
    good     = fb_seen_q && (err_abs <= (CNT_WIDTH+1)'(PHASE_TOL));
    good_inc = good_q + 1'b1;
    bad_inc  = bad_q + 1'b1;

    cnt_d     = ref_edge ? '0 : cnt_inc;
    t_d       = t_q;
    fb_seen_d = fb_seen_q;
    first_d   = first_q;
    los_d     = los_q;
    period_d  = period_q;
    err_d     = err_q;
    ev_d      = 1'b0;
    state_d   = state_q;
    good_d    = good_q;
    bad_d     = bad_q;

    if (ref_edge) begin
      fb_seen_d = fb_edge;
      t_d       = '0;
    end else if (fb_edge && !fb_seen_q) begin
      fb_seen_d = 1'b1;
      t_d       = cnt_inc;
    end

    if (ref_edge) begin
      los_d = 1'b0;
      if (first_q) begin
        first_d = 1'b0;
      end else begin
        period_d = cnt_inc;
        if (fb_seen_q) begin
          err_d = err;
          ev_d  = 1'b1;
        end
        unique case (state_q)
          UNLOCKED: if (good) begin
            if (LOCK_COUNT <= 1) begin
              state_d = LOCKED;
            end else begin
              state_d = ACQUIRING;
              good_d  = GW'(1);
            end
          end
          ACQUIRING: if (good) begin
            if (good_inc >= GW'(LOCK_COUNT)) begin
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d  = good_inc;
            end
          end else begin
            state_d = UNLOCKED;
            good_d  = '0;
          end
          LOCKED: if (!good) begin
            state_d = HOLDOVER;
            bad_d   = BW'(1);
          end
          HOLDOVER: if (good) begin
            state_d = LOCKED;
            bad_d   = '0;
          end else if (bad_inc >= BW'(UNLOCK_COUNT)) begin
            state_d = UNLOCKED;
            bad_d   = '0;
          end else begin
            bad_d   = bad_inc;
          end
          default: state_d = UNLOCKED;
        endcase
      end
    end else if (cnt_q == CNT_WIDTH'(REF_TIMEOUT)) begin
      los_d   = 1'b1;
      first_d = 1'b1;
      state_d = UNLOCKED;
      good_d  = '0;
      bad_d   = '0;
    end
  end

  always_ff @(posedge oscInput or negedge reset) begin
    if (!reset) begin
      ref_sync_q <= '0;
      fb_sync_q  <= '0;
      cnt_q      <= '0;
      t_q        <= '0;
      fb_seen_q  <= 1'b0;
      first_q    <= 1'b1;
      los_q      <= 1'b0;
      period_q   <= '0;
      err_q      <= '0;
      ev_q       <= 1'b0;
      state_q    <= UNLOCKED;
      good_q     <= '0;
      bad_q      <= '0;
    end else begin
      ref_sync_q <= {ref_sync_q[1:0], refIn};
      fb_sync_q  <= {fb_sync_q[1:0], fbIn};
      cnt_q      <= cnt_d;
      t_q        <= t_d;
      fb_seen_q  <= fb_seen_d;
      first_q    <= first_d;
      los_q      <= los_d;
      period_q   <= period_d;
      err_q      <= err_d;
      ev_q       <= ev_d;
      state_q    <= state_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
    end
  end

  assign lockState = state_q;
  assign locked    = state_q[1];
  assign phaseErr  = err_q;
  assign errValid  = ev_q;
  assign refPeriod = period_q;
  assign lossOfRef = los_q;

endmodule

// File: tb/tb_dpll_lock_detector.sv
// Directed bench for dpll_lock_detector: 1020-cycle ref periods,
// hand-computed phase errors, lock FSM walk, loss of ref and reset.
`timescale 1ns/1ps
module tb_dpll_lock_detector;

  localparam int CW = 20;

  logic                 oscInput = 1'b0;
  logic                 reset    = 1'b0;
  logic                 refIn    = 1'b0;
  logic                 fbIn     = 1'b0;
  logic                 locked;
  logic [1:0]           lockState;
  logic signed [CW:0]   phaseErr;
  logic                 errValid;
  logic [CW-1:0]        refPeriod;
  logic                 lossOfRef;

  int checks   = 0;
  int failures = 0;
  int ev_n;
  logic signed [CW:0] ev_err;

  always #50 oscInput = ~oscInput;

  dpll_lock_detector #(
    .CNT_WIDTH(CW),
    .PHASE_TOL(16),
    .LOCK_COUNT(8),
    .UNLOCK_COUNT(4),
    .REF_TIMEOUT(4096)
  ) dut (
    .oscInput (oscInput),
    .reset    (reset),
    .refIn    (refIn),
    .fbIn     (fbIn),
    .locked   (locked),
    .lockState(lockState),
    .phaseErr (phaseErr),
    .errValid (errValid),
    .refPeriod(refPeriod),
    .lossOfRef(lossOfRef)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag,
               $signed(got), $signed(exp));
    end
  endtask

  // One 1020-cycle ref period; fb rises d cycles after ref when enabled.
  task automatic run_period(input int d, input bit fb_en);
    ev_n = 0;
    for (int c = 0; c < 1020; c++) begin
      @(negedge oscInput);
      if (errValid) begin
        ev_n++;
        ev_err = phaseErr;
      end
      refIn = (c < 510);
      fbIn  = fb_en && (c >= d) && (c < d + 4);
    end
  endtask

  initial begin
    ev_err = '0;
    repeat (20) begin
      @(negedge oscInput);
      refIn = ~refIn;
      fbIn  = 1'($urandom_range(0, 1));
    end
    @(negedge oscInput);
    chk("rst_locked", locked, 0);
    chk("rst_state", lockState, 0);
    chk("rst_err", $signed(phaseErr), 0);
    chk("rst_ev", errValid, 0);
    chk("rst_period", refPeriod, 0);
    chk("rst_los", lossOfRef, 0);
    refIn = 1'b0;
    fbIn  = 1'b0;
    reset = 1'b1;

    run_period(5, 1'b1);
    chk("first_ev", ev_n, 0);
    chk("first_state", lockState, 0);
    run_period(5, 1'b1);
    chk("acq_evn", ev_n, 1);
    chk("acq_err", $signed(ev_err), 5);
    chk("acq_period", refPeriod, 1020);
    chk("acq_state", lockState, 1);
    for (int p = 3; p <= 8; p++) run_period(5, 1'b1);
    chk("pre_lock", locked, 0);
    run_period(5, 1'b1);
    chk("lock9", locked, 1);
    chk("lock9_state", lockState, 2);

    run_period(1010, 1'b1);
    run_period(100, 1'b1);
    chk("neg_err", $signed(ev_err), -10);
    chk("neg_state", lockState, 2);
    run_period(100, 1'b1);
    run_period(100, 1'b1);
    run_period(5, 1'b1);
    chk("hold_state", lockState, 3);
    chk("hold_locked", locked, 1);
    chk("hold_err", $signed(ev_err), 100);
    run_period(100, 1'b1);
    chk("relock_state", lockState, 2);
    for (int p = 0; p < 3; p++) run_period(100, 1'b1);
    chk("hold3_state", lockState, 3);
    run_period(5, 1'b1);
    chk("unlock_state", lockState, 0);
    chk("unlock_locked", locked, 0);

    run_period(7, 1'b1);
    chk("reacq_state", lockState, 1);
    run_period(5, 1'b0);
    chk("err7_evn", ev_n, 1);
    chk("err7", $signed(ev_err), 7);
    run_period(5, 1'b1);
    chk("nofb_evn", ev_n, 0);
    chk("nofb_hold", $signed(phaseErr), 7);
    chk("nofb_state", lockState, 0);
    run_period(5, 1'b1);
    chk("pre_los_state", lockState, 1);

    // ref stays low; loss is due 4096 counts after the internal edge
    for (int c = 1020; c <= 4100; c++) begin
      @(negedge oscInput);
      if (c == 4099) chk("los_early", lossOfRef, 0);
      if (c == 4100) chk("los", lossOfRef, 1);
    end
    chk("los_state", lockState, 0);
    chk("los_period", refPeriod, 1020);
    chk("los_err", $signed(phaseErr), 5);

    run_period(5, 1'b1);
    chk("restart_los", lossOfRef, 0);
    chk("restart_evn", ev_n, 0);
    run_period(5, 1'b1);
    chk("restart2_evn", ev_n, 1);
    chk("restart2_state", lockState, 1);
    for (int p = 0; p < 7; p++) run_period(5, 1'b1);
    chk("lock_again", locked, 1);

    @(negedge oscInput);
    reset = 1'b0;
    #1;
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_state", lockState, 0);
    chk("mid_rst_err", $signed(phaseErr), 0);
    chk("mid_rst_period", refPeriod, 0);
    @(negedge oscInput);
    reset = 1'b1;
    for (int p = 0; p < 8; p++) run_period(5, 1'b1);
    chk("rst_pre_lock", locked, 0);
    run_period(5, 1'b1);
    chk("rst_lock9", locked, 1);
    chk("rst_lock9_state", lockState, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
